// File: rtl/johnson_seq_ctrl_pkg.sv
// Shared definitions for the Johnson sequence controller.
//   state_t      : controller FSM encoding (IDLE, RUN, DONE)
//   SEED_DEFAULT : generator value after reset / lockout recovery
//   jc_valid     : true when a 4-bit value is one of the 8 Johnson states
//   jc_next      : one twisted-ring step
package johnson_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SEED_DEFAULT = 4'b0000;

  // A Johnson state has at most one transition between adjacent bits
  // (Q[3]..Q[0]); the lockout states all have two or three.
  function automatic logic jc_valid(input logic [3:0] q);
    logic [2:0] t;
    t = q[3:1] ^ q[2:0];
    return (t == 3'b000) || (t == 3'b001) || (t == 3'b010) || (t == 3'b100);
  endfunction

  // Q[0]<=Q[1], Q[1]<=Q[2], Q[2]<=Q[3], Q[3]<=~Q[0]
  function automatic logic [3:0] jc_next(input logic [3:0] q);
    return {~q[0], q[3:1]};
  endfunction

endpackage

// File: rtl/johnson_core.sv
// 4-bit Johnson generator register.
//   clk      : clock, rising edge
//   clr      : asynchronous active-low reset, loads SEED
//   en       : advance one step
//   load     : load load_val (wins over en)
//   load_val : value for load
//   q        : generator state
module johnson_core
  import johnson_seq_ctrl_pkg::*;
#(
  parameter logic [3:0] SEED = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= jc_next(q);
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Two-requester controller/arbiter for a 4-bit Johnson generator.
// Owns stepping, configuration loads and lockout recovery.
//   clk       : clock, rising edge
//   clr       : asynchronous active-low reset
//   req[1:0]  : level requests, held until done or abort
//   steps0/1  : step count per requester, sampled at grant
//   cfg_load  : load cfg_val into the generator (IDLE only)
//   cfg_val   : value for cfg_load
//   gnt[1:0]  : one-hot grant, held from grant through DONE
//   busy      : high in RUN and DONE
//   done      : one-cycle completion pulse
//   err       : one-cycle pulse after a lockout recovery
//   Q         : generator state
module johnson_seq_ctrl
  import johnson_seq_ctrl_pkg::*;
#(
  parameter logic [3:0]  SEED   = SEED_DEFAULT,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        req,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  input  logic              cfg_load,
  input  logic [3:0]        cfg_val,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        Q
);

  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              ptr;        // 1: requester 1 wins a tie
  logic [STEP_W-1:0] remaining;
  logic              q_valid;
  logic              abort;
  logic              win;        // 1: requester 1 is the winner
  logic [STEP_W-1:0] win_steps;
  logic              core_en;
  logic              core_load;
  logic [3:0]        core_val;

  assign q_valid   = jc_valid(Q);
  // gnt is one-hot in RUN, so this sees only the granted requester's line.
  assign abort     = (state == RUN) && ((req & gnt) == 2'b00);
  assign win       = (req == 2'b10) || ((req == 2'b11) && ptr);
  assign win_steps = win ? steps1 : steps0;

  // Recovery overrides both cfg_load and stepping; an invalid Q never steps.
  assign core_load = !q_valid || ((state == IDLE) && cfg_load);
  assign core_val  = q_valid ? cfg_val : SEED;
  assign core_en   = (state == RUN) && q_valid && !abort;

  johnson_core #(.SEED(SEED)) u_core (
    .clk      (clk),
    .clr      (clr),
    .en       (core_en),
    .load     (core_load),
    .load_val (core_val),
    .q        (Q)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      remaining <= '0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= !q_valid;
      case (state)
        IDLE: begin
          if (!cfg_load && (req != 2'b00)) begin
            gnt       <= win ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            remaining <= win_steps;
            // A zero-step grant skips RUN; DONE then raises done one
            // cycle later so the grant is still visible for two cycles.
            state     <= (win_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            ptr   <= ~gnt[1];
          end else if (q_valid) begin
            remaining <= remaining - STEP_ONE;
            if (remaining == STEP_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b0;
            ptr   <= ~gnt[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: per-cycle expected outputs
// {gnt,busy,done,err,Q} are queued as stimulus is applied and compared
// one cycle later.
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] steps0 = 4'd0;
  logic [3:0] steps1 = 4'd0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_val = 4'd0;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] Q;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  johnson_seq_ctrl #(.SEED(4'b0000), .STEP_W(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .steps0   (steps0),
    .steps1   (steps1),
    .cfg_load (cfg_load),
    .cfg_val  (cfg_val),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .Q        (Q)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {gnt, busy, done, err, Q};
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got gnt/busy/done/err/Q=%b want %b", tag, obs, expv);
  endtask

  // Queue the outputs expected after the next rising edge, then compare.
  task automatic cyc(input string tag, input logic [1:0] g, input logic b, input logic d,
                     input logic e, input logic [3:0] q);
    exp_q.push_back({g, b, d, e, q});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag_q.pop_front(), outs(), exp_q.pop_front());
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #3 clr = 1'b0;
    #1 check_eq(tag, outs(), 9'b0);
    #2 clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check_eq("reset", outs(), 9'b0);
    clr = 1'b1;

    // Requester 0, three steps
    req = 2'b01; steps0 = 4'd3;
    cyc("s1_gnt",   2'b01, 1, 0, 0, 4'b0000);
    cyc("s1_step1", 2'b01, 1, 0, 0, 4'b1000);
    cyc("s1_step2", 2'b01, 1, 0, 0, 4'b1100);
    cyc("s1_done",  2'b01, 1, 1, 0, 4'b1110);
    req = 2'b00;
    cyc("s1_idle",  2'b00, 0, 0, 0, 4'b1110);
    cyc("s1_hold",  2'b00, 0, 0, 0, 4'b1110);

    async_reset("rst_idle");

    // Tie from reset: requester 0 first, then requester 1
    req = 2'b11; steps0 = 4'd2; steps1 = 4'd2;
    cyc("s2_g0",    2'b01, 1, 0, 0, 4'b0000);
    cyc("s2_a1",    2'b01, 1, 0, 0, 4'b1000);
    cyc("s2_d0",    2'b01, 1, 1, 0, 4'b1100);
    cyc("s2_idle",  2'b00, 0, 0, 0, 4'b1100);
    cyc("s2_g1",    2'b10, 1, 0, 0, 4'b1100);
    cyc("s2_b1",    2'b10, 1, 0, 0, 4'b1110);
    cyc("s2_d1",    2'b10, 1, 1, 0, 4'b1111);
    req = 2'b00;
    cyc("s2_end",   2'b00, 0, 0, 0, 4'b1111);

    // Zero-step grant
    req = 2'b10; steps1 = 4'd0;
    cyc("s3_gnt",   2'b10, 1, 0, 0, 4'b1111);
    cyc("s3_done",  2'b10, 1, 1, 0, 4'b1111);
    req = 2'b00;
    cyc("s3_idle",  2'b00, 0, 0, 0, 4'b1111);

    // Invalid cfg load recovers to SEED with an err pulse
    cfg_load = 1'b1; cfg_val = 4'b0101;
    cyc("s4_load",  2'b00, 0, 0, 0, 4'b0101);
    cfg_load = 1'b0;
    cyc("s4_rec",   2'b00, 0, 0, 1, 4'b0000);
    cyc("s4_quiet", 2'b00, 0, 0, 0, 4'b0000);
    // Valid load while requesting: no arbitration that cycle
    cfg_load = 1'b1; cfg_val = 4'b0011; req = 2'b01;
    cyc("s4_vload", 2'b00, 0, 0, 0, 4'b0011);
    req = 2'b00; cfg_val = 4'b0000;
    cyc("s4_zero",  2'b00, 0, 0, 0, 4'b0000);
    cfg_load = 1'b0;

    // Abort after three steps; cfg_load during RUN is ignored
    req = 2'b01; steps0 = 4'd8;
    cyc("s5_gnt",   2'b01, 1, 0, 0, 4'b0000);
    cfg_load = 1'b1; cfg_val = 4'b0101;
    cyc("s5_st1",   2'b01, 1, 0, 0, 4'b1000);
    cfg_load = 1'b0;
    cyc("s5_st2",   2'b01, 1, 0, 0, 4'b1100);
    cyc("s5_st3",   2'b01, 1, 0, 0, 4'b1110);
    req = 2'b00;
    cyc("s5_abort", 2'b00, 0, 0, 0, 4'b1110);
    cyc("s5_frozen",2'b00, 0, 0, 0, 4'b1110);
    req = 2'b11; steps1 = 4'd2;
    cyc("s5_g1",    2'b10, 1, 0, 0, 4'b1110);
    cyc("s5_b1",    2'b10, 1, 0, 0, 4'b1111);
    cyc("s5_d1",    2'b10, 1, 1, 0, 4'b0111);
    req = 2'b00;
    cyc("s5_end",   2'b00, 0, 0, 0, 4'b0111);

    // Reset in the middle of RUN, then a fresh one-step request
    req = 2'b01; steps0 = 4'd5;
    cyc("s6_gnt",   2'b01, 1, 0, 0, 4'b0111);
    cyc("s6_st1",   2'b01, 1, 0, 0, 4'b0011);
    cyc("s6_st2",   2'b01, 1, 0, 0, 4'b0001);
    steps0 = 4'd1;
    async_reset("rst_run");
    cyc("s6_regnt", 2'b01, 1, 0, 0, 4'b0000);
    cyc("s6_done",  2'b01, 1, 1, 0, 4'b1000);
    req = 2'b00;
    cyc("s6_idle",  2'b00, 0, 0, 0, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
